// File: rtl/bcd_price_if.sv
// Character-in / price-out stream bundle for the ASCII price decoder.
// The decoder takes the slave side; the command source / book logic takes the master side.
interface bcd_price_if;
  logic        in_vld;
  logic [7:0]  in_dat;
  logic        in_rdy;
  logic        out_vld;
  logic [19:0] out_price;
  logic        out_err;
  logic        out_rdy;

  modport master (
    output in_vld, in_dat, out_rdy,
    input  in_rdy, out_vld, out_price, out_err
  );

  modport slave (
    input  in_vld, in_dat, out_rdy,
    output in_rdy, out_vld, out_price, out_err
  );
endinterface

// File: rtl/bcd_price_decoder.sv
// Streaming ASCII "[$]DDD.CC<term>" parser producing a packed 5-digit BCD price.
// Bad fields are swallowed up to the terminator and reported with out_err so the stream stays aligned.
module bcd_price_decoder #(
  parameter logic [7:0] TERM_CHAR    = 8'h0A,
  parameter bit         ALLOW_DOLLAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  bcd_price_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_D2,
    S_D1,
    S_D0,
    S_DOT,
    S_C1,
    S_C0,
    S_TERM,
    S_ERR
  } state_t;

  state_t      state_reg;
  logic [19:0] digit_reg;
  logic        out_vld_reg;
  logic        out_err_reg;
  logic [19:0] out_price_reg;

  logic       in_rdy;
  logic       accept;
  logic       is_digit;
  logic       is_term;
  logic       is_dollar;
  logic       is_dot;
  logic [3:0] nib;

  // Backpressure is applied to every character, so a stalled result freezes the parser too.
  assign in_rdy    = ~out_vld_reg | bus.out_rdy;
  assign accept    = bus.in_vld & in_rdy;
  assign is_digit  = (bus.in_dat >= 8'h30) && (bus.in_dat <= 8'h39);
  assign is_term   = (bus.in_dat == TERM_CHAR);
  assign is_dollar = (bus.in_dat == 8'h24) && ALLOW_DOLLAR;
  assign is_dot    = (bus.in_dat == 8'h2E);
  assign nib       = bus.in_dat[3:0];

  assign bus.in_rdy    = in_rdy;
  assign bus.out_vld   = out_vld_reg;
  assign bus.out_err   = out_err_reg;
  assign bus.out_price = out_price_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      digit_reg     <= 20'h0;
      out_vld_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
      out_price_reg <= 20'h0;
    end else begin
      if (out_vld_reg && bus.out_rdy) begin
        out_vld_reg <= 1'b0;
      end

      if (accept) begin
        if (is_term) begin
          // A terminator always closes the field; only S_TERM means all digits arrived.
          out_vld_reg   <= 1'b1;
          out_err_reg   <= (state_reg != S_TERM);
          out_price_reg <= (state_reg == S_TERM) ? digit_reg : 20'h0;
          state_reg     <= S_IDLE;
        end else begin
          state_reg <= S_ERR;
          case (state_reg)
            S_IDLE: begin
              if (is_dollar) begin
                state_reg <= S_D2;
              end else if (is_digit) begin
                digit_reg[19:16] <= nib;
                state_reg        <= S_D1;
              end
            end
            S_D2: begin
              if (is_digit) begin
                digit_reg[19:16] <= nib;
                state_reg        <= S_D1;
              end
            end
            S_D1: begin
              if (is_digit) begin
                digit_reg[15:12] <= nib;
                state_reg        <= S_D0;
              end
            end
            S_D0: begin
              if (is_digit) begin
                digit_reg[11:8] <= nib;
                state_reg       <= S_DOT;
              end
            end
            S_DOT: begin
              if (is_dot) begin
                state_reg <= S_C1;
              end
            end
            S_C1: begin
              if (is_digit) begin
                digit_reg[7:4] <= nib;
                state_reg      <= S_C0;
              end
            end
            S_C0: begin
              if (is_digit) begin
                digit_reg[3:0] <= nib;
                state_reg      <= S_TERM;
              end
            end
            default: begin
              state_reg <= S_ERR;
            end
          endcase
        end
      end
    end
  end

endmodule
